fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits between the SISC control FSM and instruction memory. It owns the program counter and the instruction register, and computes the next PC (increment, PC-relative branch, or absolute branch) from the ctrl strobes. It runs a req/ack handshake with a variable-latency instruction memory and reports busy and error status back to ctrl.

Parameters:
PC_W, 16, program counter and imem address width
IR_W, 32, instruction width; IR[IR_W-1:IR_W-4] is the opcode, IR[15:0] is the immediate
TIMEOUT, 15, maximum cycles to wait for imem_ack before aborting (valid range 1..255)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_f  in  1  reset, asynchronous, active-low
pc_rst  in  1  ctrl: force PC to 0 when pc_write=1
pc_write  in  1  ctrl: update PC this cycle
pc_sel  in  1  ctrl: 0 selects increment, 1 selects branch target
br_sel  in  1  ctrl: 0 selects relative target, 1 selects absolute target
ir_load  in  1  ctrl: one-cycle pulse that starts a fetch at the current PC
imem_req  out  1  registered request to instruction memory
imem_addr  out  PC_W  registered fetch address, stable while imem_req=1
imem_rdata  in  IR_W  instruction data, valid when imem_ack=1
imem_ack  in  1  memory completion strobe
pc_out  out  PC_W  current PC register
ir_out  out  IR_W  instruction register
opcode  out  4  equals ir_out[IR_W-1:IR_W-4], feeds ctrl
ir_valid  out  1  ir_out holds the data of the most recent fetch
fetch_busy  out  1  fetch in progress (stall request to ctrl)
fetch_err  out  1  sticky error flag

Behaviour:
- Reset (rst_f=0, asynchronous): pc_out=0, ir_out=0, ir_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, timeout counter=0, FSM=IDLE.
- PC update happens on a clock edge with pc_write=1. Priority order:
  - pc_rst=1: PC becomes 0.
  - pc_sel=0: PC becomes PC+1.
  - pc_sel=1, br_sel=1: PC becomes IR[15:0], zero-extended or truncated to PC_W.
  - pc_sel=1, br_sel=0: PC becomes PC + sign-extended IR[15:0].
- All PC arithmetic is modulo 2^PC_W. There is no overflow detection. 0xFFFF+1 wraps to 0x0000.
- With pc_write=0, PC holds. PC updates are independent of the FSM; they are never blocked by fetch_busy.
- FSM states:
  - IDLE: waiting for a fetch.
  - WAIT: request outstanding.
- IDLE to WAIT, on ir_load=1:
  - imem_addr is loaded with the PC value before any same-cycle increment.
  - imem_req=1, fetch_busy=1, ir_valid=0, counter=0.
  - Request latency is one cycle: imem_req is first high the cycle after the ir_load pulse.
- In WAIT, imem_ack=1 at a clock edge:
  - ir_out is loaded from imem_rdata; ir_valid=1; imem_req=0; fetch_busy=0; FSM returns to IDLE.
  - ir_out and ir_valid update on the same edge. Minimum total fetch latency is 2 edges after ir_load.
- In WAIT without an ack: counter increments each cycle. When counter reaches TIMEOUT:
  - Abort the fetch and return to IDLE.
  - imem_req=0, fetch_busy=0, fetch_err=1.
  - ir_out is unchanged and ir_valid stays 0.
- imem_ack while imem_req=0 is ignored: no state change, no error.
- ir_load while in WAIT is ignored and sets fetch_err=1. The outstanding fetch continues unaffected.
- pc_rst=1 with pc_write=1 while in WAIT: the fetch is aborted. FSM goes to IDLE, imem_req=0, fetch_busy=0, ir_valid=0. An ack arriving on that same edge is discarded. fetch_err is not set.
- fetch_err clears only on reset.
- ir_out holds its last value between fetches; it changes only on an accepted ack.
- Asserting rst_f mid-fetch drops imem_req asynchronously. A late ack after reset is ignored.

Test Plan:
- Reset, then pulse pc_rst+pc_write, then ir_load; memory returns 0x2120_0005 with 3-cycle latency -> imem_addr=0x0000. imem_req is high for 3 cycles. ir_out=0x2120_0005, opcode=2, ir_valid=1. pc_out=0x0001 after the same-cycle pc_write with pc_sel=0.
- PC=0x0010, IR[15:0]=0xFFFC, pc_sel=1, br_sel=0, pc_write=1 -> pc_out=0x000C. Repeat with br_sel=1 -> pc_out=0xFFFC.
- PC=0xFFFF, pc_write=1, pc_sel=0 -> pc_out=0x0000. A fetch at 0xFFFF uses imem_addr=0xFFFF.
- ir_load with no ack for TIMEOUT=15 cycles -> imem_req falls after 15 cycles, fetch_err=1, ir_out unchanged, ir_valid=0. A following ir_load with an immediate ack succeeds, and fetch_err stays 1.
- ir_load during WAIT, then ack -> fetch_err=1 and ir_out equals the first fetch's data. Separately: an ack with imem_req=0 causes no change.
- In WAIT, pc_rst+pc_write on the same edge as ack=1 -> pc_out=0, ir_valid=0, ir_out unchanged, fetch_err=0. Asserting rst_f low mid-WAIT clears imem_req immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int unsigned PC_W = 16,
  parameter int unsigned IR_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [IR_W-1:0] imem_rdata;
  logic            imem_ack;

  // Fetch side issues requests, memory side returns data.
  modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, computes next PC, runs imem req/ack with timeout.
module fetch_unit #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned IR_W    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  fetch_unit_if.master    bus,
  output logic [PC_W-1:0] pc_out,
  output logic [IR_W-1:0] ir_out,
  output logic [3:0]      opcode,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            fetch_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IMM_W = 16;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IMM_W-1:0]  imm;
  logic [CNT_W-1:0]  cnt_nxt;

  assign imm     = ir_q[IMM_W-1:0];
  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Next-state logic: PC update is independent of the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    req_d   = req_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (pc_write) begin
      if (pc_rst)       pc_d = '0;
      else if (!pc_sel) pc_d = pc_q + PC_W'(1);
      else if (br_sel)  pc_d = PC_W'(imm);
      else              pc_d = pc_q + PC_W'($signed(imm));
    end

    case (state_q)
      S_IDLE: begin
        if (ir_load) begin
          state_d = S_WAIT;
          addr_d  = pc_q;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A second load while outstanding is dropped but flagged.
        if (ir_load) err_d = 1'b1;
        if (pc_write && pc_rst) begin
          // PC reset aborts the fetch; a same-edge ack is discarded.
          state_d = S_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (bus.imem_ack) begin
          state_d = S_IDLE;
          ir_d    = bus.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign pc_out        = pc_q;
  assign ir_out        = ir_q;
  assign opcode        = ir_q[IR_W-1 -: 4];
  assign ir_valid      = valid_q;
  assign fetch_busy    = busy_q;
  assign fetch_err     = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue of expected fetched instructions.
module tb_fetch_unit;
  localparam int unsigned PC_W = 16;
  localparam int unsigned IR_W = 32;

  logic clk = 1'b0;
  logic rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [PC_W-1:0] pc_out;
  logic [IR_W-1:0] ir_out;
  logic [3:0]      opcode;
  logic            ir_valid, fetch_busy, fetch_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [IR_W-1:0] exp_q[$];

  fetch_unit_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .IR_W(IR_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .bus(bus),
    .pc_out(pc_out), .ir_out(ir_out), .opcode(opcode), .ir_valid(ir_valid),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch: load pulse (optionally with same-cycle PC increment), ack after lat cycles.
  task automatic fetch(input logic [31:0] data, input int lat, input logic [15:0] exp_addr,
                       input logic inc);
    exp_q.push_back(data);
    ir_load = 1'b1; pc_write = inc; pc_sel = 1'b0; pc_rst = 1'b0;
    step();
    ir_load = 1'b0; pc_write = 1'b0;
    chk("addr", 32'(bus.imem_addr), 32'(exp_addr));
    chk("busy", 32'(fetch_busy), 32'd1);
    for (int i = 1; i < lat; i++) begin
      chk("req_wait", 32'(bus.imem_req), 32'd1);
      step();
    end
    chk("req_last", 32'(bus.imem_req), 32'd1);
    bus.imem_rdata = data; bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
    chk("req_done", 32'(bus.imem_req), 32'd0);
    chk("valid_done", 32'(ir_valid), 32'd1);
    chk("busy_done", 32'(fetch_busy), 32'd0);
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("ir_out", ir_out, exp_q.pop_front());
  endtask

  task automatic pc_op(input logic rst, input logic sel, input logic br);
    pc_write = 1'b1; pc_rst = rst; pc_sel = sel; br_sel = br;
    step();
    pc_write = 1'b0; pc_rst = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic do_reset();
    rst_f = 1'b0;
    #3;
    rst_f = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    ir_load = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    @(negedge clk);
    // Reset values
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_ir", ir_out, 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_f = 1'b1;
    @(negedge clk);

    // PC reset, then fetch at 0 with 3-cycle latency and same-cycle increment
    pc_op(1'b1, 1'b0, 1'b0);
    chk("pc_rst", 32'(pc_out), 32'd0);
    fetch(32'h2120_0005, 3, 16'h0000, 1'b1);
    chk("opcode", 32'(opcode), 32'd2);
    chk("pc_inc_same", 32'(pc_out), 32'h0001);

    // Branches: absolute to 0x0010, then relative -4 and absolute 0xFFFC
    fetch(32'h1000_0010, 1, 16'h0001, 1'b0);
    pc_op(1'b0, 1'b1, 1'b1);
    chk("pc_abs_10", 32'(pc_out), 32'h0010);
    fetch(32'h1000_FFFC, 2, 16'h0010, 1'b0);
    pc_op(1'b0, 1'b1, 1'b0);
    chk("pc_rel_neg", 32'(pc_out), 32'h000C);
    pc_op(1'b0, 1'b1, 1'b1);
    chk("pc_abs_fffc", 32'(pc_out), 32'hFFFC);

    // Wrap: reach 0xFFFF, fetch there, then increment to 0
    fetch(32'h3000_FFFF, 1, 16'hFFFC, 1'b0);
    pc_op(1'b0, 1'b1, 1'b1);
    chk("pc_ffff", 32'(pc_out), 32'hFFFF);
    fetch(32'h3000_FFFF, 2, 16'hFFFF, 1'b0);
    pc_op(1'b0, 1'b0, 1'b0);
    chk("pc_wrap", 32'(pc_out), 32'h0000);

    // Timeout: request stays up 15 cycles, then aborts with sticky error
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    chk("to_valid", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 14; i++) begin
      chk("to_req_hi", 32'(bus.imem_req), 32'd1);
      step();
    end
    chk("to_req_hi_last", 32'(bus.imem_req), 32'd1);
    step();
    chk("to_req_lo", 32'(bus.imem_req), 32'd0);
    chk("to_busy", 32'(fetch_busy), 32'd0);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_ir_keep", ir_out, 32'h3000_FFFF);
    chk("to_valid_lo", 32'(ir_valid), 32'd0);
    fetch(32'h4000_0001, 1, 16'h0000, 1'b0);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);

    // ir_load while waiting: flagged, first fetch completes
    do_reset();
    chk("rst2_err", 32'(fetch_err), 32'd0);
    exp_q.push_back(32'h5000_AAAA);
    ir_load = 1'b1;
    step();
    chk("dbl_addr", 32'(bus.imem_addr), 32'd0);
    pc_op(1'b0, 1'b0, 1'b0);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    chk("dbl_err", 32'(fetch_err), 32'd1);
    chk("dbl_req", 32'(bus.imem_req), 32'd1);
    chk("dbl_addr_hold", 32'(bus.imem_addr), 32'd0);
    bus.imem_rdata = 32'h5000_AAAA; bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("dbl_valid", 32'(ir_valid), 32'd1);
    chk("dbl_ir", ir_out, exp_q.pop_front());

    // Ack with no outstanding request is ignored
    bus.imem_rdata = 32'h6666_6666; bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("stray_ir", ir_out, 32'h5000_AAAA);
    chk("stray_valid", 32'(ir_valid), 32'd1);
    chk("stray_req", 32'(bus.imem_req), 32'd0);
    chk("stray_busy", 32'(fetch_busy), 32'd0);

    // PC reset on the ack edge aborts and discards the data
    do_reset();
    fetch(32'h7000_0007, 1, 16'h0000, 1'b0);
    pc_op(1'b0, 1'b0, 1'b0);
    pc_op(1'b0, 1'b0, 1'b0);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    chk("abort_addr", 32'(bus.imem_addr), 32'd2);
    pc_write = 1'b1; pc_rst = 1'b1;
    bus.imem_rdata = 32'h8888_8888; bus.imem_ack = 1'b1;
    step();
    pc_write = 1'b0; pc_rst = 1'b0; bus.imem_ack = 1'b0;
    chk("abort_pc", 32'(pc_out), 32'd0);
    chk("abort_valid", 32'(ir_valid), 32'd0);
    chk("abort_ir", ir_out, 32'h7000_0007);
    chk("abort_err", 32'(fetch_err), 32'd0);
    chk("abort_req", 32'(bus.imem_req), 32'd0);
    chk("abort_busy", 32'(fetch_busy), 32'd0);

    // Async reset mid-wait drops the request without a clock edge
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    chk("ar_req_hi", 32'(bus.imem_req), 32'd1);
    #2 rst_f = 1'b0;
    #1 chk("ar_req_async", 32'(bus.imem_req), 32'd0);
    chk("ar_busy_async", 32'(fetch_busy), 32'd0);
    rst_f = 1'b1;
    @(negedge clk);
    bus.imem_rdata = 32'h9999_9999; bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("late_ack_ir", ir_out, 32'd0);
    chk("late_ack_valid", 32'(ir_valid), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end
endmodule
